// File: rtl/ps_pkg.sv
// Shared types and helpers for the ps8 requester agent.
package ps_pkg;

   localparam int unsigned PS_N = 8;

   typedef logic [$clog2(PS_N)-1:0] ps_idx_t;

   typedef struct packed {
      logic    is_onehot;
      ps_idx_t idx;
   } onehot_t;

   // Reports whether exactly one bit is set and the index of the highest set bit.
   function automatic onehot_t onehot_chk(input logic [PS_N-1:0] vec);
      onehot_t     r;
      int unsigned cnt;
      r   = '0;
      cnt = 0;
      for (int unsigned i = 0; i < PS_N; i++) begin
         if (vec[i]) begin
            cnt   = cnt + 1;
            r.idx = ps_idx_t'(i);
         end
      end
      r.is_onehot = (cnt == 1);
      return r;
   endfunction

endpackage

// File: rtl/ps_client_slot.sv
// Per-client state: pending-token counter, starvation age, sticky overflow.
module ps_client_slot #(
   parameter int CNT_W     = 3,
   parameter int AGE_LIMIT = 12
) (
   input  logic clock,
   input  logic reset,
   input  logic push,
   input  logic take,
   input  logic en,
   output logic req,
   output logic starve,
   output logic overflow
);

   localparam int AGE_W = $clog2(AGE_LIMIT + 1);
   localparam logic [CNT_W-1:0] PEND_MAX = '1;
   localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(AGE_LIMIT);

   logic [CNT_W-1:0] pend, pend_nxt;
   logic [AGE_W-1:0] age, age_nxt;
   logic             ovf_nxt;

   assign req    = (pend != '0);
   assign starve = (age == AGE_MAX);

   // Next counter/age/overflow values from this cycle's push and take.
   always_comb begin
      pend_nxt = pend;
      ovf_nxt  = overflow;
      age_nxt  = age;
      if (push && !take) begin
         if (pend == PEND_MAX) ovf_nxt  = 1'b1;
         else                  pend_nxt = pend + CNT_W'(1);
      end else if (!push && take) begin
         pend_nxt = pend - CNT_W'(1);
      end
      // Stalled cycles (en=0) leave age untouched.
      if (take || pend_nxt == '0)         age_nxt = '0;
      else if (req && en && age != AGE_MAX) age_nxt = age + AGE_W'(1);
   end

   // Slot state register.
   always_ff @(posedge clock) begin
      if (reset) begin
         pend     <= '0;
         age      <= '0;
         overflow <= 1'b0;
      end else begin
         pend     <= pend_nxt;
         age      <= age_nxt;
         overflow <= ovf_nxt;
      end
   end

endmodule

// File: rtl/ps_req_agent.sv
// Requester-side front end for the ps8 priority selector tree.
module ps_req_agent
   import ps_pkg::*;
#(
   parameter int N         = PS_N,
   parameter int CNT_W     = 3,
   parameter int AGE_LIMIT = 12
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [N-1:0]         push,
   input  logic                 stall_in,
   input  logic [N-1:0]         gnt,
   output logic [N-1:0]         req,
   output logic                 en,
   output logic                 grant_valid,
   output logic [$clog2(N)-1:0] grant_idx,
   output logic [N-1:0]         starve,
   output logic [N-1:0]         overflow,
   output logic                 proto_err
);

   onehot_t      gnt_chk;
   logic         legal;
   logic         illegal;
   logic [N-1:0] take;

   // Grant legality: enabled, exactly one bit, and on a requesting client.
   always_comb begin
      en      = ~stall_in & (|req);
      gnt_chk = onehot_chk(gnt);
      legal   = en & gnt_chk.is_onehot & (|(gnt & req));
      illegal = (|gnt) & ~legal;
      take    = legal ? gnt : '0;
   end

   // Grant reporting and sticky protocol error.
   always_ff @(posedge clock) begin
      if (reset) begin
         grant_valid <= 1'b0;
         grant_idx   <= '0;
         proto_err   <= 1'b0;
      end else begin
         grant_valid <= legal;
         if (legal)   grant_idx <= gnt_chk.idx;
         if (illegal) proto_err <= 1'b1;
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_slot
      ps_client_slot #(
         .CNT_W     (CNT_W),
         .AGE_LIMIT (AGE_LIMIT)
      ) u_slot (
         .clock    (clock),
         .reset    (reset),
         .push     (push[g]),
         .take     (take[g]),
         .en       (en),
         .req      (req[g]),
         .starve   (starve[g]),
         .overflow (overflow[g])
      );
   end

endmodule

// File: tb/tb_ps_req_agent.sv
// Self-checking bench for ps_req_agent: directed scenarios plus random traffic
// against a behavioural model of the requester agent.
module tb_ps_req_agent;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] push;
   logic       stall_in;
   logic [7:0] gnt;
   logic [7:0] req;
   logic       en;
   logic       grant_valid;
   logic [2:0] grant_idx;
   logic [7:0] starve;
   logic [7:0] overflow;
   logic       proto_err;

   logic [7:0] gnt_r;
   logic [7:0] sel_gnt;
   bit         auto_gnt;
   bit         chk_on;

   int n_pass  = 0;
   int n_total = 0;

   // Behavioural model state.
   int m_pend [8];
   int m_age  [8];
   bit m_ovf  [8];
   bit m_perr;
   bit m_gv;
   int m_gi;

   always #5 clock = ~clock;

   ps_req_agent #(.N(8), .CNT_W(3), .AGE_LIMIT(12)) dut (
      .clock       (clock),
      .reset       (reset),
      .push        (push),
      .stall_in    (stall_in),
      .gnt         (gnt),
      .req         (req),
      .en          (en),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx),
      .starve      (starve),
      .overflow    (overflow),
      .proto_err   (proto_err)
   );

   // Stand-in selector: highest requesting index wins while enabled.
   always_comb begin
      sel_gnt = '0;
      if (en) begin
         for (int i = 0; i < 8; i++) if (req[i]) sel_gnt = 8'(1) << i;
      end
   end
   assign gnt = auto_gnt ? sel_gnt : gnt_r;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Compare DUT against the model, then advance the model by one clock.
   always @(negedge clock) begin : cmp_model
      logic [7:0] er, es, eo;
      logic       ee, legal, tk;
      int         gi_new;
      er = '0; es = '0; eo = '0;
      for (int i = 0; i < 8; i++) begin
         er[i] = (m_pend[i] != 0);
         es[i] = (m_age[i] == 12);
         eo[i] = m_ovf[i];
      end
      ee = !stall_in && (er != 0);
      if (chk_on) begin
         chk("req",         32'(req),         32'(er));
         chk("en",          32'(en),          32'(ee));
         chk("starve",      32'(starve),      32'(es));
         chk("overflow",    32'(overflow),    32'(eo));
         chk("proto_err",   32'(proto_err),   32'(m_perr));
         chk("grant_valid", 32'(grant_valid), 32'(m_gv));
         chk("grant_idx",   32'(grant_idx),   32'(m_gi));
      end
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            m_pend[i] = 0; m_age[i] = 0; m_ovf[i] = 0;
         end
         m_perr = 0; m_gv = 0; m_gi = 0;
      end else begin
         legal  = ee && ($countones(gnt) == 1) && ((gnt & er) != 0);
         gi_new = 0;
         if (gnt != 0 && !legal) m_perr = 1;
         for (int i = 0; i < 8; i++) begin
            tk = legal && gnt[i];
            if (tk) gi_new = i;
            if (tk)                              m_age[i] = 0;
            else if (er[i] && ee && m_age[i] < 12) m_age[i] = m_age[i] + 1;
            if (push[i] && !tk) begin
               if (m_pend[i] == 7) m_ovf[i] = 1;
               else                m_pend[i] = m_pend[i] + 1;
            end else if (!push[i] && tk) begin
               m_pend[i] = m_pend[i] - 1;
            end
            if (m_pend[i] == 0) m_age[i] = 0;
         end
         m_gv = legal;
         if (legal) m_gi = gi_new;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drain(input string nm);
      push = '0; stall_in = 0; auto_gnt = 1;
      for (int k = 0; k < 40 && req != 0; k++) tick();
      chk(nm, 32'(req), 32'h0);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin
         m_pend[i] = 0; m_age[i] = 0; m_ovf[i] = 0;
      end
      m_perr = 0; m_gv = 0; m_gi = 0;
      chk_on = 0; auto_gnt = 0; gnt_r = '0;
      reset = 1; push = '0; stall_in = 0;

      // 1: reset
      tick(); tick();
      reset = 0;
      chk_on = 1;
      chk("rst_req", 32'(req), 32'h0);
      chk("rst_en", 32'(en), 32'h0);
      chk("rst_gv", 32'(grant_valid), 32'h0);
      chk("rst_ovf", 32'(overflow), 32'h0);

      // 2: two clients, selector echo
      push = 8'h81; tick();
      push = 8'h00; auto_gnt = 1;
      chk("t2_req", 32'(req), 32'h81);
      tick();
      chk("t2_gv7", 32'(grant_valid), 32'h1);
      chk("t2_idx7", 32'(grant_idx), 32'h7);
      chk("t2_req0", 32'(req), 32'h01);
      tick();
      chk("t2_idx0", 32'(grant_idx), 32'h0);
      chk("t2_reqz", 32'(req), 32'h00);
      tick();
      chk("t2_gvz", 32'(grant_valid), 32'h0);
      chk("t2_idxhold", 32'(grant_idx), 32'h0);

      // 3: overflow on client 2
      auto_gnt = 0; gnt_r = '0; push = 8'h04;
      for (int k = 0; k < 9; k++) tick();
      push = '0;
      chk("t3_ovf", 32'(overflow), 32'h04);
      drain("t3_drain");
      chk("t3_ovf_sticky", 32'(overflow), 32'h04);

      // 4: push and take on the same client in one cycle
      auto_gnt = 0; push = 8'h08; tick();
      push = 8'h08; auto_gnt = 1; tick();
      chk("t4_gv", 32'(grant_valid), 32'h1);
      chk("t4_idx", 32'(grant_idx), 32'h3);
      chk("t4_req", 32'(req), 32'h08);
      drain("t4_drain");

      // 5: starvation of client 0 while client 7 is served
      auto_gnt = 0; gnt_r = '0; push = 8'h81; tick();
      push = 8'h80; gnt_r = 8'h80;
      for (int k = 0; k < 6; k++) tick();
      stall_in = 1; push = '0; gnt_r = '0;
      for (int k = 0; k < 3; k++) tick();
      stall_in = 0; push = 8'h80; gnt_r = 8'h80;
      for (int k = 0; k < 5; k++) tick();
      chk("t5_nostarve", 32'(starve), 32'h0);
      tick();
      chk("t5_starve", 32'(starve), 32'h01);
      push = '0; gnt_r = 8'h01; tick();
      chk("t5_clear", 32'(starve), 32'h0);
      chk("t5_idx", 32'(grant_idx), 32'h0);
      drain("t5_drain");

      // 6: illegal grants
      auto_gnt = 0; gnt_r = '0; push = 8'h0C; tick();
      push = '0; gnt_r = 8'h10; tick();
      chk("t6_perr", 32'(proto_err), 32'h1);
      chk("t6_gv", 32'(grant_valid), 32'h0);
      chk("t6_req", 32'(req), 32'h0C);
      gnt_r = 8'h0C; tick();
      chk("t6_gv2", 32'(grant_valid), 32'h0);
      chk("t6_req2", 32'(req), 32'h0C);
      gnt_r = '0; reset = 1; tick();
      reset = 0;
      chk("t6_perr_rst", 32'(proto_err), 32'h0);

      // Random traffic
      for (int k = 0; k < 3000; k++) begin
         int r;
         reset    = ($urandom_range(0, 299) == 0);
         push     = 8'($urandom & $urandom);
         stall_in = ($urandom_range(0, 7) == 0);
         r        = $urandom_range(0, 9);
         if (r < 8) begin
            auto_gnt = 1;
         end else if (r == 8) begin
            auto_gnt = 0;
            gnt_r    = 8'(1) << $urandom_range(0, 7);
         end else begin
            auto_gnt = 0;
            gnt_r    = 8'($urandom);
         end
         tick();
      end

      chk_on = 0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
